dlx_fetch_issue: RTL and testbench

- Instruction fetch/issue stage feeding the instruction decoder of the multi-stage DLX core.
- Holds the PC and requests 32-bit words from instruction memory over a req/ack interface.
- Presents each fetched instruction, with its opc/func fields, to decode over a valid/ready handshake.
- Consumes the decoder's Branch, jflag and jrflag outputs to redirect fetch and flush wrong-path instructions.

---
 rtl/dlx_fetch_issue.sv | 169 ++++++++++++++++
 tb/tb_dlx_fetch_issue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_fetch_issue.sv
// DLX fetch/issue stage: owns the PC, fetches over req/ack and hands one instruction
// at a time to decode, redirecting on branch/jump. Optional buffer: DLX_FETCH_PREFETCH_EN.
module dlx_fetch_issue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic [5:0]  opc,
  output logic [5:0]  func,
  input  logic        branch,
  input  logic        jflag,
  input  logic        jrflag,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target
);
  localparam logic [31:0] PC_STEP = 32'(PC_INC);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  logic [31:0] ipc_q, ipc_d;
`ifdef DLX_FETCH_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic [31:0] pf_word_q, pf_word_d;
  logic [31:0] pf_pc_q, pf_pc_d;
`endif

  logic        redirect, hs;
  logic [31:0] target_raw, target;

  assign redirect   = branch | jflag | jrflag;
  assign target_raw = jrflag ? jr_target : br_target;
  assign target     = {target_raw[31:2], 2'b00};
  // A redirect masks the slot, so a wrong-path word can never be accepted.
  assign inst_valid = valid_q & ~redirect;
  assign hs         = inst_valid & inst_ready;

  assign imem_req   = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign inst_word  = word_q;
  assign inst_pc    = ipc_q;
  assign opc        = word_q[31:26];
  assign func       = word_q[5:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    word_d       = word_q;
    ipc_d        = ipc_q;
`ifdef DLX_FETCH_PREFETCH_EN
    pf_valid_d   = pf_valid_q;
    pf_word_d    = pf_word_q;
    pf_pc_d      = pf_pc_q;
`endif
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
`ifdef DLX_FETCH_PREFETCH_EN
          pf_valid_d = 1'b0;
`endif
          // Without the ack the address must stay put until memory completes.
          if (!imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else begin
`ifdef DLX_FETCH_PREFETCH_EN
          if (hs) valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = pc_q + PC_STEP;
            if (!valid_q || hs) begin
              valid_d = 1'b1;
              word_d  = imem_rdata;
              ipc_d   = pc_q;
            end else begin
              pf_valid_d = 1'b1;
              pf_word_d  = imem_rdata;
              pf_pc_d    = pc_q;
              state_d    = HOLD;
            end
          end
`else
          if (imem_ack) begin
            pc_d    = pc_q + PC_STEP;
            valid_d = 1'b1;
            word_d  = imem_rdata;
            ipc_d   = pc_q;
            state_d = HOLD;
          end
`endif
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
`ifdef DLX_FETCH_PREFETCH_EN
          pf_valid_d = 1'b0;
`endif
        end else if (hs) begin
          state_d = FETCH;
`ifdef DLX_FETCH_PREFETCH_EN
          valid_d    = pf_valid_q;
          word_d     = pf_word_q;
          ipc_d      = pf_pc_q;
          pf_valid_d = 1'b0;
`else
          valid_d = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (redirect) pc_d = target;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      valid_q      <= 1'b0;
      word_q       <= '0;
      ipc_q        <= '0;
`ifdef DLX_FETCH_PREFETCH_EN
      pf_valid_q   <= 1'b0;
      pf_word_q    <= '0;
      pf_pc_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      word_q       <= word_d;
      ipc_q        <= ipc_d;
`ifdef DLX_FETCH_PREFETCH_EN
      pf_valid_q   <= pf_valid_d;
      pf_word_q    <= pf_word_d;
      pf_pc_q      <= pf_pc_d;
`endif
    end
  end
endmodule

// File: tb/tb_dlx_fetch_issue.sv
// Directed bench for dlx_fetch_issue: sequential fetch, stall, redirects, drain, reset, wrap.
module tb_dlx_fetch_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_word, inst_pc;
  logic [5:0]  opc, func;
  logic        branch, jflag, jrflag;
  logic [31:0] br_target, jr_target;

  logic        ack_drv, pf_mode;
  logic [31:0] rdata_drv;
  int          pass_cnt = 0;
  int          total = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0: memw = 32'h0000_0020;
      32'h4: memw = 32'h8C22_0004;
      32'h8: memw = 32'h2001_0005;
      32'hC: memw = 32'h1000_0003;
      default: memw = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign imem_ack   = pf_mode ? imem_req : ack_drv;
  assign imem_rdata = pf_mode ? memw(imem_addr) : rdata_drv;

  dlx_fetch_issue dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word), .inst_pc(inst_pc),
    .opc(opc), .func(func), .branch(branch), .jflag(jflag), .jrflag(jrflag),
    .br_target(br_target), .jr_target(jr_target)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // Acks the current request one cycle after it is seen; leaves the stage in HOLD.
  task automatic ack_one(input logic [31:0] data);
    cyc(); ack_drv = 1'b1; rdata_drv = data;
    cyc(); ack_drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ack_drv = 1'b0; rdata_drv = '0; pf_mode = 1'b0; inst_ready = 1'b0;
    branch = 1'b0; jflag = 1'b0; jrflag = 1'b0; br_target = '0; jr_target = '0;
    cyc(); cyc();
    @(negedge clk);
    total++;
    if ({imem_req, inst_valid, inst_word, inst_pc, imem_addr} !== {2'b00, 96'h0})
      $display("FAIL reset_state req=%b vld=%b word=%h pc=%h addr=%h want all zero",
               imem_req, inst_valid, inst_word, inst_pc, imem_addr);
    else pass_cnt++;
    cyc(); rst_n = 1'b1;
  endtask

  task automatic test_seq_fetch();
    logic [5:0] e_opc [4] = '{6'h00, 6'h23, 6'h08, 6'h04};
    logic [5:0] e_fn  [4] = '{6'h20, 6'h04, 6'h05, 6'h03};
    bit ok;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      total++;
      if (!ok || imem_addr !== 32'(i * 4))
        $display("FAIL seq_addr%0d got %h (req seen %0d) want %h", i, imem_addr, ok, 32'(i * 4));
      else pass_cnt++;
      ack_one(memw(32'(i * 4)));
      total++;
      if ({inst_valid, inst_pc, inst_word, opc, func} !== {1'b1, 32'(i * 4), memw(32'(i * 4)), e_opc[i], e_fn[i]})
        $display("FAIL seq_inst%0d vld=%b pc=%h word=%h opc=%h func=%h want pc=%h opc=%h func=%h",
                 i, inst_valid, inst_pc, inst_word, opc, func, 32'(i * 4), e_opc[i], e_fn[i]);
      else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_stall_and_branch();
    bit ok;
    wait_req(ok);
    inst_ready = 1'b0;
    ack_one(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({inst_valid, inst_word, inst_pc, imem_req, imem_addr} !== {1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 32'h14})
        $display("FAIL stall%0d vld=%b word=%h pc=%h req=%b addr=%h want 1/deadbeef/10/0/14",
                 i, inst_valid, inst_word, inst_pc, imem_req, imem_addr);
      else pass_cnt++;
      cyc(); @(negedge clk);
    end
    cyc(); branch = 1'b1; br_target = 32'h0000_0103; inst_ready = 1'b1;
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) $display("FAIL branch_mask vld=%b want 0", inst_valid);
    else pass_cnt++;
    cyc(); branch = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL branch_refetch req=%b addr=%h vld=%b want 1/00000100/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
    ack_one(32'h1234_5678);
    total++;
    if ({inst_valid, inst_pc, inst_word} !== {1'b1, 32'h100, 32'h1234_5678})
      $display("FAIL branch_inst vld=%b pc=%h word=%h want 1/00000100/12345678", inst_valid, inst_pc, inst_word);
    else pass_cnt++;
    inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0;
  endtask

  task automatic test_drain();
    bit ok;
    wait_req(ok);
    cyc(); jrflag = 1'b1; jr_target = 32'h0000_0042;
    cyc(); jrflag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ack_drv = 1'b1; rdata_drv = 32'hFFFF_FFFF; end
      @(negedge clk);
      total++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h104, 1'b0})
        $display("FAIL drain%0d req=%b addr=%h vld=%b want 1/00000104/0", i, imem_req, imem_addr, inst_valid);
      else pass_cnt++;
      cyc();
    end
    ack_drv = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h40, 1'b0})
      $display("FAIL drain_refetch req=%b addr=%h vld=%b want 1/00000040/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
    ack_one(32'hAAAA_5555);
    total++;
    if ({inst_valid, inst_pc, inst_word} !== {1'b1, 32'h40, 32'hAAAA_5555})
      $display("FAIL drain_inst vld=%b pc=%h word=%h want 1/00000040/aaaa5555", inst_valid, inst_pc, inst_word);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h44})
      $display("FAIL mid_req req=%b addr=%h want 1/00000044", imem_req, imem_addr);
    else pass_cnt++;
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; ack_drv = 1'b1; rdata_drv = 32'h7777_7777;
    @(negedge clk);
    total++;
    if ({imem_req, inst_valid, inst_word, inst_pc, imem_addr} !== {2'b00, 96'h0})
      $display("FAIL mid_reset req=%b vld=%b word=%h pc=%h addr=%h want all zero",
               imem_req, inst_valid, inst_word, inst_pc, imem_addr);
    else pass_cnt++;
    cyc(); ack_drv = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL mid_restart req=%b addr=%h vld=%b want 1/00000000/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    cyc(); jflag = 1'b1; br_target = 32'hFFFF_FFFD; ack_drv = 1'b1; rdata_drv = 32'h0BAD_0BAD;
    cyc(); jflag = 1'b0; ack_drv = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL jmp_ack_discard req=%b addr=%h vld=%b want 1/fffffffc/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
    ack_one(32'h0C00_0001);
    total++;
    if ({inst_valid, inst_pc, inst_word} !== {1'b1, 32'hFFFF_FFFC, 32'h0C00_0001})
      $display("FAIL wrap_inst vld=%b pc=%h word=%h want 1/fffffffc/0c000001", inst_valid, inst_pc, inst_word);
    else pass_cnt++;
    inst_ready = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_addr req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else pass_cnt++;
  endtask

`ifdef DLX_FETCH_PREFETCH_EN
  task automatic test_back_to_back();
    pf_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(); @(negedge clk);
      total++;
      if ({inst_valid, inst_pc} !== {1'b1, 32'(k * 4)})
        $display("FAIL b2b%0d vld=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 32'(k * 4));
      else pass_cnt++;
    end
    cyc(); inst_ready = 1'b0;
    cyc(); @(negedge clk);
    total++;
    if ({imem_req, inst_valid, inst_pc} !== {1'b0, 1'b1, 32'd24})
      $display("FAIL pf_full req=%b vld=%b pc=%h want 0/1/00000018", imem_req, inst_valid, inst_pc);
    else pass_cnt++;
    cyc(); inst_ready = 1'b1;
    cyc(); branch = 1'b1; br_target = 32'h0000_0200;
    @(negedge clk);
    total++;
    if ({inst_valid, inst_pc} !== {1'b0, 32'd28})
      $display("FAIL pf_unload vld=%b pc=%h want 0/0000001c", inst_valid, inst_pc);
    else pass_cnt++;
    cyc(); branch = 1'b0;
    @(negedge clk);
    total++;
    if ({inst_valid, imem_addr} !== {1'b0, 32'h200})
      $display("FAIL pf_flush vld=%b addr=%h want 0/00000200", inst_valid, imem_addr);
    else pass_cnt++;
    cyc(); @(negedge clk);
    total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h200})
      $display("FAIL pf_redirect_inst vld=%b pc=%h want 1/00000200", inst_valid, inst_pc);
    else pass_cnt++;
    pf_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall_and_branch();
    test_drain();
    test_reset_mid();
    test_wrap();
`ifdef DLX_FETCH_PREFETCH_EN
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
